branch_target_predictor: RTL and testbench

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

---
 rtl/branch_target_predictor.sv | 127 ++++++++++++
 tb/tb_branch_target_predictor.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Branch target predictor: direct-mapped BTB with per-entry saturating
// direction counters, combinational fetch-stage lookup, MEM-stage
// resolution/mispredict detection and saturating statistics counters.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   enable           pipeline advance; all state changes are gated by it
//   bp_clear         invalidate every entry (wins over a same-cycle update)
//   fetch_pc         PC being fetched; pred_taken / pred_next_pc answer for it
//   upd_*            resolved control-flow instruction from the MEM stage
//   mispredict       carried prediction disagrees with the resolved next PC
//   redirect_pc      resolved next PC
//   branch_cnt       resolved-branch count (saturating)
//   mispred_cnt      mispredict count (saturating)
module branch_target_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              bp_clear,
    input  logic [31:0]       fetch_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_next_pc,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_pc,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0]   fetch_idx;
    logic [TAG_W-1:0]   fetch_tag;
    logic               fetch_hit;

    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic [31:0]        correct_pc;

    // The carried prediction bit is implied by upd_pred_pc; keep it
    // referenced so the port stays connected without affecting logic.
    logic               pred_taken_unused;
    assign pred_taken_unused = upd_pred_taken;

    // Fetch-stage lookup reads registered state only, so a same-cycle
    // update to the same index is seen on the following cycle.
    always_comb begin
        fetch_idx    = fetch_pc[IDX_W+1:2];
        fetch_tag    = fetch_pc[31:IDX_W+2];
        fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken   = fetch_hit && ctr_q[fetch_idx][CTR_W-1];
        pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
    end

    always_comb begin
        upd_idx     = upd_pc[IDX_W+1:2];
        upd_tag     = upd_pc[31:IDX_W+2];
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        correct_pc  = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd4;
        redirect_pc = correct_pc;
        mispredict  = upd_valid && (upd_pred_pc != correct_pc);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (enable) begin
            if (upd_valid && upd_is_branch && (branch_cnt != '1))
                branch_cnt <= branch_cnt + 1'b1;
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + 1'b1;

            if (bp_clear) begin
                for (int unsigned i = 0; i < ENTRIES; i++)
                    valid_q[i] <= 1'b0;
            end else if (upd_valid) begin
                if (upd_hit) begin
                    if (upd_is_branch) begin
                        if (upd_taken) begin
                            if (ctr_q[upd_idx] != CTR_MAX)
                                ctr_q[upd_idx] <= ctr_q[upd_idx] + 1'b1;
                            target_q[upd_idx] <= upd_target;
                        end else if (ctr_q[upd_idx] != '0) begin
                            ctr_q[upd_idx] <= ctr_q[upd_idx] - 1'b1;
                        end
                    end else begin
                        // A non-branch aliasing a live entry means the entry is stale.
                        valid_q[upd_idx] <= 1'b0;
                    end
                end else if (upd_is_branch && upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= upd_target;
                    ctr_q[upd_idx]    <= CTR_WEAK;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

    localparam int ENT   = 16;
    localparam int IDXW  = 4;
    localparam int CWEAK = 2;
    localparam int CMAX  = 3;

    logic        CLK = 1'b0;
    logic        RST, enable, bp_clear;
    logic [31:0] fetch_pc;
    logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_pc;

    logic        pred_taken, mispredict;
    logic [31:0] pred_next_pc, redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        s_pred_taken, s_mispredict;
    logic [31:0] s_pred_next_pc, s_redirect_pc;
    logic [3:0]  s_branch_cnt, s_mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    branch_target_predictor #(.ENTRIES(16), .CTR_W(2), .STAT_W(16)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .bp_clear(bp_clear),
        .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_target_predictor #(.ENTRIES(16), .CTR_W(2), .STAT_W(4)) dut_s (
        .CLK(CLK), .RST(RST), .enable(enable), .bp_clear(bp_clear),
        .fetch_pc(fetch_pc), .pred_taken(s_pred_taken), .pred_next_pc(s_pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    // Reference model: a table of entries keyed by index, plus plain counts.
    logic        m_valid  [ENT];
    logic [31:0] m_tag    [ENT];
    logic [31:0] m_target [ENT];
    int          m_ctr    [ENT];
    int          m_bcnt, m_mcnt, s_bcnt, s_mcnt;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == (pc >> (IDXW + 2)));
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= CWEAK);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_taken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_correct();
        return (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd4;
    endfunction

    function automatic logic m_misp();
        return upd_valid && (upd_pred_pc != m_correct());
    endfunction

    task automatic model_apply();
        int i;
        if (RST) begin
            for (int k = 0; k < ENT; k++) begin
                m_valid[k] = 1'b0; m_tag[k] = '0; m_target[k] = '0; m_ctr[k] = 0;
            end
            m_bcnt = 0; m_mcnt = 0; s_bcnt = 0; s_mcnt = 0;
        end else if (enable) begin
            if (upd_valid && upd_is_branch) begin
                if (m_bcnt < 65535) m_bcnt++;
                if (s_bcnt < 15) s_bcnt++;
            end
            if (m_misp()) begin
                if (m_mcnt < 65535) m_mcnt++;
                if (s_mcnt < 15) s_mcnt++;
            end
            i = m_idx(upd_pc);
            if (bp_clear) begin
                for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
            end else if (upd_valid) begin
                if (m_hit(upd_pc)) begin
                    if (!upd_is_branch) m_valid[i] = 1'b0;
                    else if (upd_taken) begin
                        m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
                        m_target[i] = upd_target;
                    end else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end else if (upd_is_branch && upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i] = upd_pc >> (IDXW + 2);
                    m_target[i] = upd_target;
                    m_ctr[i] = CWEAK;
                end
            end
        end
    endtask

    // Advance one clock: model sees the same inputs the DUT samples.
    task automatic tick();
        model_apply();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 0; enable = 1; bp_clear = 0; upd_valid = 0; upd_is_branch = 0;
        upd_taken = 0; upd_pc = 32'h0; upd_target = 32'h0;
        upd_pred_taken = 0; upd_pred_pc = 32'h4;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] ppc);
        upd_valid = 1; upd_pc = pc; upd_is_branch = br; upd_taken = tk;
        upd_target = tgt; upd_pred_pc = ppc; upd_pred_taken = (ppc != pc + 32'd4);
    endtask

    task automatic do_reset();
        idle(); RST = 1; enable = 0; tick(); RST = 0; enable = 1;
    endtask

    task automatic test_reset();
        do_reset();
        fetch_pc = 32'h40; #2;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %0b exp 0", pred_taken); end
        n_checks++;
        if (pred_next_pc !== 32'h44) begin n_fail++; $display("FAIL reset_next_pc got %h exp 00000044", pred_next_pc); end
        n_checks++;
        if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
        end
        set_upd(32'h200, 1'b0, 1'b0, 32'h0, 32'h300); #2;
        n_checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h204) begin
            n_fail++; $display("FAIL reset_misp_comb got %0b/%h exp 1/00000204", mispredict, redirect_pc);
        end
        idle();
    endtask

    // Same-cycle allocate + lookup, then visibility on the next cycle.
    task automatic test_alloc();
        do_reset();
        fetch_pc = 32'h40;
        set_upd(32'h40, 1'b1, 1'b1, 32'h100, 32'h44); #2;
        n_checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h100) begin
            n_fail++; $display("FAIL alloc_misp got %0b/%h exp 1/00000100", mispredict, redirect_pc);
        end
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alloc_same_cycle got %0b exp 0", pred_taken); end
        tick(); idle(); #2;
        n_checks++;
        if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd1) begin
            n_fail++; $display("FAIL alloc_counts got %0d/%0d exp 1/1", branch_cnt, mispred_cnt);
        end
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h100) begin
            n_fail++; $display("FAIL alloc_lookup got %0b/%h exp 1/00000100", pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_counter();
        logic        exp_t [8];
        logic        tk    [8];
        logic [31:0] exp_n;
        // ctr starts at 2: nt,nt -> 1,0; t x4 -> 1,2,3,3; nt,nt -> 2,1
        tk    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        fetch_pc = 32'h40;
        for (int s = 0; s < 8; s++) begin
            set_upd(32'h40, 1'b1, tk[s], 32'h180, 32'h44);
            tick(); idle(); #2;
            exp_n = exp_t[s] ? 32'h180 : 32'h44;
            n_checks++;
            if (pred_taken !== exp_t[s] || pred_next_pc !== exp_n) begin
                n_fail++;
                $display("FAIL counter_step%0d got %0b/%h exp %0b/%h", s, pred_taken, pred_next_pc, exp_t[s], exp_n);
            end
        end
    endtask

    task automatic test_alias();
        do_reset();
        set_upd(32'h40, 1'b1, 1'b1, 32'h100, 32'h44); tick();
        set_upd(32'h80, 1'b1, 1'b1, 32'h200, 32'h84); tick(); idle();
        fetch_pc = 32'h40; #2;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h44) begin
            n_fail++; $display("FAIL alias_old got %0b/%h exp 0/00000044", pred_taken, pred_next_pc);
        end
        fetch_pc = 32'h80; #2;
        n_checks++;
        if (pred_next_pc !== 32'h200) begin n_fail++; $display("FAIL alias_new got %h exp 00000200", pred_next_pc); end
        set_upd(32'h80, 1'b0, 1'b0, 32'h0, 32'h84); tick(); idle(); #2;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h84) begin
            n_fail++; $display("FAIL alias_inval got %0b/%h exp 0/00000084", pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_clear_enable();
        do_reset();
        set_upd(32'h40, 1'b1, 1'b1, 32'h100, 32'h44); tick();
        bp_clear = 1; set_upd(32'hC0, 1'b1, 1'b1, 32'h300, 32'hC4); tick(); idle();
        fetch_pc = 32'h40; #2;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL clear_old got %0b exp 0", pred_taken); end
        fetch_pc = 32'hC0; #2;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL clear_upd got %0b exp 0", pred_taken); end
        n_checks++;
        if (branch_cnt !== 16'd2 || mispred_cnt !== 16'd2) begin
            n_fail++; $display("FAIL clear_stats got %0d/%0d exp 2/2", branch_cnt, mispred_cnt);
        end
        enable = 0; set_upd(32'h40, 1'b1, 1'b1, 32'h100, 32'h44); tick(); idle();
        fetch_pc = 32'h40; #2;
        n_checks++;
        if (pred_taken !== 1'b0 || branch_cnt !== 16'd2 || mispred_cnt !== 16'd2) begin
            n_fail++; $display("FAIL disabled_upd got %0b %0d/%0d exp 0 2/2", pred_taken, branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_stats_sat();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            set_upd(32'h1000 + 32'(k * 64), 1'b1, 1'b1, 32'h8000, 32'h1000 + 32'(k * 64) + 32'd4);
            tick();
        end
        idle(); #2;
        n_checks++;
        if (s_branch_cnt !== 4'd15 || s_mispred_cnt !== 4'd15) begin
            n_fail++; $display("FAIL stat_sat4 got %0d/%0d exp 15/15", s_branch_cnt, s_mispred_cnt);
        end
        n_checks++;
        if (branch_cnt !== 16'd20 || mispred_cnt !== 16'd20) begin
            n_fail++; $display("FAIL stat_16 got %0d/%0d exp 20/20", branch_cnt, mispred_cnt);
        end
        set_upd(32'h40, 1'b1, 1'b1, 32'h100, 32'h44); bp_clear = 1; RST = 1; tick(); idle();
        fetch_pc = 32'h1000; #2;
        n_checks++;
        if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 || s_branch_cnt !== 4'd0 || pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got %0d/%0d/%0d/%0b exp 0/0/0/0", branch_cnt, mispred_cnt, s_branch_cnt, pred_taken);
        end
    endtask

    task automatic test_random();
        logic [31:0] e_next, e_redir, ppc;
        logic        e_tk, e_mp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            RST      = ($urandom_range(0, 199) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            bp_clear = ($urandom_range(0, 39) == 0);
            fetch_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            upd_pc   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 3) == 0) upd_pc = fetch_pc;
            upd_valid     = ($urandom_range(0, 9) < 7);
            upd_is_branch = ($urandom_range(0, 9) < 8);
            upd_taken     = $urandom_range(0, 1);
            upd_target    = {$urandom_range(0, 255), 2'b00};
            ppc = m_next(upd_pc);
            if ($urandom_range(0, 1) == 0) ppc = ppc ^ {$urandom_range(0, 7), 2'b00};
            upd_pred_pc    = ppc;
            upd_pred_taken = (ppc != upd_pc + 32'd4);
            #2;
            e_tk = m_taken(fetch_pc); e_next = m_next(fetch_pc);
            e_redir = m_correct(); e_mp = m_misp();
            n_checks++;
            if (pred_taken !== e_tk || pred_next_pc !== e_next) begin
                n_fail++; $display("FAIL rnd_lookup c%0d got %0b/%h exp %0b/%h", c, pred_taken, pred_next_pc, e_tk, e_next);
            end
            n_checks++;
            if (mispredict !== e_mp || redirect_pc !== e_redir) begin
                n_fail++; $display("FAIL rnd_misp c%0d got %0b/%h exp %0b/%h", c, mispredict, redirect_pc, e_mp, e_redir);
            end
            n_checks++;
            if (branch_cnt !== 16'(m_bcnt) || mispred_cnt !== 16'(m_mcnt)) begin
                n_fail++; $display("FAIL rnd_stats c%0d got %0d/%0d exp %0d/%0d", c, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
            end
            n_checks++;
            if (s_branch_cnt !== 4'(s_bcnt) || s_mispred_cnt !== 4'(s_mcnt)) begin
                n_fail++; $display("FAIL rnd_stats4 c%0d got %0d/%0d exp %0d/%0d", c, s_branch_cnt, s_mispred_cnt, s_bcnt, s_mcnt);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        fetch_pc = 32'h0;
        #1;
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_clear_enable();
        test_stats_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
